// File: rtl/idma_aw_release_arbiter.sv
// idma_aw_release_arbiter
//
// Shares one downstream AXI AW port between NumChan backend channels. A
// non-decoupled write request is only released once the first R beat of its
// matching read has arrived: each such beat deposits a credit on its channel,
// and each released non-decoupled AW consumes one. Decoupled requests need no
// credit. Eligible channels are granted round-robin into a single registered
// output stage.
//
// Handshake semantics (all AW ports): a beat transfers on a rising clock edge
// where valid and ready are both high. The upstream side gets aw_ready_o
// one-hot (or zero) and may look at it combinationally. The downstream side
// holds aw_req_o / aw_chan_o stable while aw_valid_o is high and aw_ready_i is
// low.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   r_first_i          per-channel pulse: first R beat of a non-decoupled read
//   aw_req_i           per-channel AW payload
//   aw_decouple_i      per-channel: request needs no credit
//   aw_valid_i         per-channel request valid
//   aw_ready_o         per-channel request accepted (one-hot or zero)
//   aw_req_o           shared AW payload
//   aw_valid_o         shared AW valid (registered)
//   aw_ready_i         shared AW ready
//   aw_chan_o          channel index of the beat in aw_req_o
//   busy_o             credits, pending requests or an output beat exist
//   cnt_overflow_o     r_first_i hit a saturated credit counter this cycle
module idma_aw_release_arbiter #(
  parameter int unsigned NumChan       = 2,
  parameter int unsigned NumAxInFlight = 2,
  parameter type         axi_aw_chan_t = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumChan-1:0]           r_first_i,
  input  axi_aw_chan_t [NumChan-1:0]   aw_req_i,
  input  logic [NumChan-1:0]           aw_decouple_i,
  input  logic [NumChan-1:0]           aw_valid_i,
  output logic [NumChan-1:0]           aw_ready_o,
  output axi_aw_chan_t                 aw_req_o,
  output logic                         aw_valid_o,
  input  logic                         aw_ready_i,
  output logic [$clog2(NumChan)-1:0]   aw_chan_o,
  output logic                         busy_o,
  output logic                         cnt_overflow_o
);

  localparam int unsigned CntW  = $clog2(NumAxInFlight + 1);
  localparam int unsigned ChanW = $clog2(NumChan);
  localparam logic [CntW-1:0]  CntMax   = CntW'(NumAxInFlight);
  localparam logic [ChanW-1:0] LastChan = ChanW'(NumChan - 1);

  logic [CntW-1:0]  credit_q [NumChan];
  logic [CntW-1:0]  credit_d [NumChan];
  logic [ChanW-1:0] prio_q, prio_d;
  axi_aw_chan_t     out_req_q, out_req_d;
  logic [ChanW-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;

  logic [NumChan-1:0] eligible;
  logic [NumChan-1:0] consume;
  logic               can_load;
  logic               grant_valid;
  logic [ChanW-1:0]   grant_idx;
  logic               any_credit;

  always_comb begin
    int unsigned      cand;
    logic [ChanW-1:0] cand_idx;

    // The stage can take a new beat when empty or when its beat leaves now.
    can_load = !out_valid_q | aw_ready_i;

    // A same-cycle r_first_i makes the channel eligible before the credit
    // is registered, so a release can happen in the cycle the data arrives.
    for (int unsigned i = 0; i < NumChan; i++) begin
      eligible[i] = aw_valid_i[i] &
                    (aw_decouple_i[i] | (credit_q[i] != '0) | r_first_i[i]);
    end

    // Round-robin scan starting at prio_q; the first eligible channel wins.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumChan; k++) begin
      cand     = (32'(prio_q) + k) % NumChan;
      cand_idx = ChanW'(cand);
      if (can_load && !grant_valid && eligible[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end

    aw_ready_o = '0;
    if (grant_valid) aw_ready_o[grant_idx] = 1'b1;

    prio_d = prio_q;
    if (grant_valid) prio_d = (grant_idx == LastChan) ? '0 : grant_idx + ChanW'(1);

    // Credit bookkeeping: an arrival and a consume in the same cycle cancel.
    cnt_overflow_o = 1'b0;
    any_credit     = 1'b0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      consume[i]  = aw_ready_o[i] & !aw_decouple_i[i];
      credit_d[i] = credit_q[i];
      if (r_first_i[i] && !consume[i]) begin
        if (credit_q[i] == CntMax) cnt_overflow_o = 1'b1;
        else                       credit_d[i] = credit_q[i] + CntW'(1);
      end else if (!r_first_i[i] && consume[i]) begin
        credit_d[i] = credit_q[i] - CntW'(1);
      end
      any_credit = any_credit | (credit_q[i] != '0);
    end

    // Output stage: drop the beat on handshake, load a new one on grant.
    out_valid_d = out_valid_q & !aw_ready_i;
    out_req_d   = out_req_q;
    out_chan_d  = out_chan_q;
    if (grant_valid) begin
      out_valid_d = 1'b1;
      out_req_d   = aw_req_i[grant_idx];
      out_chan_d  = grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumChan; i++) credit_q[i] <= '0;
      prio_q      <= '0;
      out_req_q   <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumChan; i++) credit_q[i] <= credit_d[i];
      prio_q      <= prio_d;
      out_req_q   <= out_req_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign aw_req_o   = out_req_q;
  assign aw_chan_o  = out_chan_q;
  assign aw_valid_o = out_valid_q;
  assign busy_o     = any_credit | (|aw_valid_i) | out_valid_q;

endmodule

// File: tb/tb_idma_aw_release_arbiter.sv
// Bench for idma_aw_release_arbiter with 4 channels, 2 credits per channel
// and a 16-bit payload. Each payload carries {channel, cycle sequence} so a
// stale or misrouted beat is visible. Expected output beats are queued when
// the bench expects a grant and checked when the shared port handshakes.
module tb_idma_aw_release_arbiter;

  localparam int NC = 4;
  localparam int PW = 16;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [NC-1:0]       r_first_i;
  logic [NC-1:0][PW-1:0] aw_req_i;
  logic [NC-1:0]       aw_decouple_i;
  logic [NC-1:0]       aw_valid_i;
  logic [NC-1:0]       aw_ready_o;
  logic [PW-1:0]       aw_req_o;
  logic                aw_valid_o;
  logic                aw_ready_i;
  logic [1:0]          aw_chan_o;
  logic                busy_o;
  logic                cnt_overflow_o;

  idma_aw_release_arbiter #(
    .NumChan       (NC),
    .NumAxInFlight (2),
    .axi_aw_chan_t (logic [PW-1:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .r_first_i      (r_first_i),
    .aw_req_i       (aw_req_i),
    .aw_decouple_i  (aw_decouple_i),
    .aw_valid_i     (aw_valid_i),
    .aw_ready_o     (aw_ready_o),
    .aw_req_o       (aw_req_o),
    .aw_valid_o     (aw_valid_o),
    .aw_ready_i     (aw_ready_i),
    .aw_chan_o      (aw_chan_o),
    .busy_o         (busy_o),
    .cnt_overflow_o (cnt_overflow_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [PW+1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [11:0]   seq = '0;
  logic [PW+1:0] bp_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] d,
                       input logic [NC-1:0] rf, input logic rdy);
    seq++;
    aw_valid_i    = v;
    aw_decouple_i = d;
    r_first_i     = rf;
    aw_ready_i    = rdy;
    for (int c = 0; c < NC; c++) aw_req_i[c] = {4'(c), seq};
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Check the per-channel grant and queue the beat(s) it should produce.
  task automatic chk_rdy(input logic [NC-1:0] exp_rdy, input string tag);
    check(tag, 32'(aw_ready_o), 32'(exp_rdy));
    for (int c = 0; c < NC; c++)
      if (exp_rdy[c]) exp_q.push_back({2'(c), aw_req_i[c]});
  endtask

  task automatic tick(input logic [NC-1:0] exp_rdy, input string tag);
    sample();
    chk_rdy(exp_rdy, tag);
    advance();
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && aw_valid_o && aw_ready_i) begin
      if (exp_q.size() == 0) begin
        check("beat_without_expectation", 32'(exp_q.size()), 32'd1);
      end else begin
        check("out_beat", 32'({aw_chan_o, aw_req_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    drive('0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    sample();
    check("rst_aw_valid_o", 32'(aw_valid_o), 32'd0);
    check("rst_aw_req_o", 32'(aw_req_o), 32'd0);
    check("rst_aw_chan_o", 32'(aw_chan_o), 32'd0);
    check("rst_aw_ready_o", 32'(aw_ready_o), 32'd0);
    check("rst_overflow", 32'(cnt_overflow_o), 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    drive('0, '0, '0, 1'b1);
    sample();
    check("idle_busy", 32'(busy_o), 32'd0);
    advance();

    // Round robin, all decoupled, one beat per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 4'hF, '0, 1'b1);
      sample();
      chk_rdy(4'(1 << (k % 4)), "rr_grant");
      if (k > 0) check("rr_back_to_back", 32'(aw_valid_o), 32'd1);
      advance();
    end
    drive('0, '0, '0, 1'b1);
    sample();
    check("rr_last_beat", 32'(aw_valid_o), 32'd1);
    chk_rdy('0, "rr_idle");
    advance();
    sample();
    check("rr_drained_valid", 32'(aw_valid_o), 32'd0);
    check("rr_drained_busy", 32'(busy_o), 32'd0);
    advance();

    // Gated release: ch0 waits for its first R beat.
    for (int k = 0; k < 5; k++) begin
      drive(4'h1, '0, '0, 1'b1);
      tick('0, "gate_wait");
    end
    drive(4'h1, '0, 4'h1, 1'b1);
    tick(4'h1, "gate_release");
    drive('0, '0, '0, 1'b1);
    sample();
    check("gate_out_valid", 32'(aw_valid_o), 32'd1);
    check("gate_out_chan", 32'(aw_chan_o), 32'd0);
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(4'h1, '0, '0, 1'b1);
      tick('0, "gate_credit_still_zero");
    end
    drive('0, '0, '0, 1'b1);
    sample();
    check("gate_busy_clear", 32'(busy_o), 32'd0);
    advance();

    // Decoupled bypass on ch1.
    drive(4'h2, 4'h2, '0, 1'b1);
    tick(4'h2, "dec_grant");
    drive('0, '0, '0, 1'b1);
    sample();
    check("dec_out_valid", 32'(aw_valid_o), 32'd1);
    check("dec_out_chan", 32'(aw_chan_o), 32'd1);
    advance();
    sample();
    check("dec_no_credit", 32'(busy_o), 32'd0);
    advance();

    // Backpressure: ch0 holds one credit, ch2 beat stalled for 3 cycles.
    drive('0, '0, 4'h1, 1'b1);
    sample();
    check("bp_credit_no_ovf", 32'(cnt_overflow_o), 32'd0);
    advance();
    drive(4'h4, 4'h4, '0, 1'b1);
    bp_beat = {2'd2, aw_req_i[2]};
    tick(4'h4, "bp_load");
    for (int k = 0; k < 3; k++) begin
      drive(4'b1001, 4'b1000, '0, 1'b0);
      sample();
      check("bp_no_grant", 32'(aw_ready_o), 32'd0);
      check("bp_valid_held", 32'(aw_valid_o), 32'd1);
      check("bp_chan_stable", 32'(aw_chan_o), 32'd2);
      check("bp_req_stable", 32'(aw_req_o), 32'(bp_beat[PW-1:0]));
      advance();
    end
    drive(4'b1001, 4'b1000, '0, 1'b1);
    tick(4'b1000, "bp_resume_ch3");
    drive(4'b0001, '0, '0, 1'b1);
    tick(4'b0001, "bp_credit_kept");
    drive(4'b0001, '0, '0, 1'b1);
    tick('0, "bp_credit_used");
    drive('0, '0, '0, 1'b1);
    sample();
    check("bp_busy_clear", 32'(busy_o), 32'd0);
    advance();

    // Credit accumulation and saturation on ch0.
    for (int k = 0; k < 3; k++) begin
      drive('0, '0, 4'h1, 1'b1);
      sample();
      check("sat_overflow", 32'(cnt_overflow_o), (k == 2) ? 32'd1 : 32'd0);
      advance();
    end
    drive('0, '0, '0, 1'b1);
    sample();
    check("sat_overflow_pulse_end", 32'(cnt_overflow_o), 32'd0);
    check("sat_busy", 32'(busy_o), 32'd1);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(4'h1, '0, '0, 1'b1);
      tick((k < 2) ? 4'h1 : 4'h0, "sat_grants");
    end
    drive('0, '0, '0, 1'b1);
    advance();
    sample();
    check("sat_busy_clear", 32'(busy_o), 32'd0);
    advance();

    // Same-cycle arrival and consume leave the credit at 1.
    drive('0, '0, 4'h1, 1'b1);
    advance();
    drive(4'h1, '0, 4'h1, 1'b1);
    sample();
    chk_rdy(4'h1, "sim_grant");
    check("sim_no_ovf", 32'(cnt_overflow_o), 32'd0);
    advance();
    drive(4'h1, '0, '0, 1'b1);
    tick(4'h1, "sim_credit_held");
    drive(4'h1, '0, '0, 1'b1);
    tick('0, "sim_credit_drained");

    // Reset mid-burst with a credit on ch1 and a beat in the stage.
    drive('0, '0, 4'h2, 1'b1);
    advance();
    drive(4'hF, 4'hF, '0, 1'b1);
    tick(4'h2, "burst0");
    drive(4'hF, 4'hF, '0, 1'b1);
    tick(4'h4, "burst1");
    drive('0, '0, '0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_aw_valid_o", 32'(aw_valid_o), 32'd0);
    check("arst_aw_req_o", 32'(aw_req_o), 32'd0);
    check("arst_aw_chan_o", 32'(aw_chan_o), 32'd0);
    check("arst_aw_ready_o", 32'(aw_ready_o), 32'd0);
    check("arst_overflow", 32'(cnt_overflow_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(4'h2, '0, '0, 1'b1);
      tick('0, "post_rst_credit_gone");
    end
    drive(4'hF, 4'hF, '0, 1'b1);
    tick(4'h1, "post_rst_prio_zero");
    drive('0, '0, '0, 1'b1);
    sample();
    check("post_rst_out_chan", 32'(aw_chan_o), 32'd0);
    advance();
    sample();
    check("post_rst_busy", 32'(busy_o), 32'd0);
    advance();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idma_aw_release_arbiter.md
# idma_aw_release_arbiter

Shares one downstream AXI `AW` port between `NumChan` backend channels. A channel's write request is released only after the first `R` beat of its matching read has arrived, which keeps writes out of the memory system until their data exists. Decoupled requests bypass this gating. The block sits between the per-channel backend `AW` queues and the shared write manager port. It tracks outstanding read-release credits per channel, grants the eligible channels round-robin, and drives the shared port from a single registered output stage.

## Interface
Parameters:
- `NumChan`, 2: number of requesting channels; must be ≥ 2.
- `NumAxInFlight`, 2: maximum credits per channel. Counter width is `$clog2(NumAxInFlight+1)`.
- `axi_aw_chan_t`, logic: AXI4 `AW` payload type.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `r_first_i`, in, NumChan: per-channel pulse marking a handshaked first `R` beat of a non-decoupled read.
- `aw_req_i`, in, NumChan × axi_aw_chan_t: per-channel `AW` payload.
- `aw_decouple_i`, in, NumChan: the request at channel i is decoupled and needs no credit.
- `aw_valid_i`, in, NumChan: per-channel request valid.
- `aw_ready_o`, out, NumChan: per-channel request accepted. One-hot or zero.
- `aw_req_o`, out, axi_aw_chan_t: shared `AW` payload.
- `aw_valid_o`, out, 1: shared `AW` valid.
- `aw_ready_i`, in, 1: shared `AW` ready.
- `aw_chan_o`, out, $clog2(NumChan): index of the channel whose request is in `aw_req_o`.
- `busy_o`, out, 1: arbiter holds credits, a pending request or an output beat.
- `cnt_overflow_o`, out, 1: single-cycle pulse when an `r_first_i` hits a saturated counter.

## Operation
- Each channel i has a credit counter `credit_q[i]`.
  - Next value: `credit_q[i] + r_first_i[i] - consume[i]`.
  - `consume[i] = aw_ready_o[i] & !aw_decouple_i[i]`.
- An `r_first_i` and a consume in the same cycle leave the counter unchanged.
- Saturation: if `credit_q[i] == NumAxInFlight` and `r_first_i[i]` arrives without a consume, the counter holds and `cnt_overflow_o` is 1 for that cycle.
- Channel i is eligible when `aw_valid_i[i] & (aw_decouple_i[i] | credit_q[i] != 0 | r_first_i[i])`. The same-cycle `r_first_i` bypass is required.
- Round-robin priority pointer `prio_q`, reset 0:
  - The grant goes to the first eligible channel scanning `prio_q`, `prio_q+1`, … modulo `NumChan`.
  - After a grant to channel g, `prio_q` becomes `(g+1) mod NumChan`.
  - Without a grant, `prio_q` is unchanged.
- A grant occurs only when the output stage can load: it is empty, or `aw_valid_o & aw_ready_i` this cycle.
  - On a grant, `aw_ready_o[g] = 1` and the stage loads `aw_req_i[g]` and g.
- Output stage: a single register holding payload, channel index and valid.
  - While `aw_valid_o = 1 & aw_ready_i = 0`, `aw_req_o` and `aw_chan_o` are stable.
- `busy_o = |credit_q | |aw_valid_i | aw_valid_o`.

## Timing
- Reset values: `aw_valid_o` = 0; `aw_req_o` = '0; `aw_chan_o` = 0; `aw_ready_o` = 0; `cnt_overflow_o` = 0; all credits 0; `prio_q` = 0.
- After reset, `busy_o` = 0 while all `aw_valid_i` are 0.
- Reset asserted mid-operation discards the output beat, all credits and the pointer immediately. No recovery of in-flight state.
- Latency:
  - A grant in cycle t gives `aw_valid_o` = 1 from cycle t+1.
  - `r_first_i` in cycle t can grant in cycle t.
- Throughput: one `AW` per cycle when `aw_ready_i` stays high. The combinational path `aw_ready_i` → `aw_ready_o` is permitted.
- `aw_ready_o` depends combinationally on `aw_valid_i`, `aw_decouple_i`, `r_first_i`, `aw_valid_o` and `aw_ready_i`. `aw_valid_o` depends only on registers.
- Simultaneous `r_first_i` on several channels all update their own counters in the same cycle.

## Test plan
- Gated release:
  - Stimulus: ch0 valid, non-decoupled, no credit, for 5 cycles; `r_first_i[0]` at cycle 5; `aw_ready_i` = 1.
  - Response: `aw_ready_o[0]` at cycle 5 only, `aw_valid_o` at cycle 6 with `aw_chan_o` = 0, `credit_q[0]` stays 0.
- Decoupled bypass:
  - Stimulus: ch1 valid, `aw_decouple_i[1]` = 1, no credits.
  - Response: granted in cycle 0, output at cycle 1, `credit_q[1]` unchanged.
- Round robin:
  - Stimulus: 4 channels, all decoupled and valid continuously, `aw_ready_i` = 1.
  - Response: `aw_chan_o` sequence is 0,1,2,3,0,… at one beat per cycle.
- Backpressure:
  - Stimulus: `aw_ready_i` = 0 for 3 cycles with a beat loaded.
  - Response: `aw_req_o` and `aw_chan_o` are stable, no `aw_ready_o` asserted, and credits are unchanged despite eligible channels.
- Credit accumulation and saturation:
  - Stimulus: `NumAxInFlight` = 2; three `r_first_i[0]` pulses with no ch0 request.
  - Response: credit reads 1, 2, 2; `cnt_overflow_o` pulses on the third pulse.
  - Follow-up: three ch0 requests then yield exactly 2 grants before stalling.
- Simultaneous event and reset:
  - Stimulus: credit 1 with `r_first_i[0]` and a ch0 grant in the same cycle.
  - Response: credit stays 1.
  - Then `rst_ni` pulled low mid-burst: all outputs and counters return to their reset values asynchronously.
